// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared constants, channel state type and width helper for clkdiv_multi
package clkdiv_pkg;

  localparam int MAX_CH        = 16;
  localparam int MAX_CNT_W     = 32;
  localparam int DEFAULT_DIV_C = 25_000_000;

  // State is held at the widest supported counter width; unused upper bits stay zero.
  typedef struct packed {
    logic [MAX_CNT_W-1:0] cnt;
    logic [MAX_CNT_W-1:0] div_act;
    logic [MAX_CNT_W-1:0] div_shadow;
    logic                 pending;
    logic                 clk_div;
  } chan_state_t;

  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clkdiv_multi_if.sv
// rtl/clkdiv_multi_if.sv - enable, divisor-load handshake and divided outputs of clkdiv_multi
interface clkdiv_multi_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 26
);
  localparam int CH_W = clkdiv_pkg::ch_w(NUM_CH);

  logic [NUM_CH-1:0] en;
  logic              load;
  logic [CH_W-1:0]   load_ch;
  logic [CNT_W-1:0]  load_val;
  logic              load_ack;
  logic              load_err;
  logic [NUM_CH-1:0] clk_div;
  logic [NUM_CH-1:0] tick;

  modport master (
    output en, load, load_ch, load_val,
    input  load_ack, load_err, clk_div, tick
  );

  modport slave (
    input  en, load, load_ch, load_val,
    output load_ack, load_err, clk_div, tick
  );

endinterface

// File: rtl/clkdiv_chan.sv
// rtl/clkdiv_chan.sv - one divider channel: half-period counter, shadow divisor commit, tick
module clkdiv_chan import clkdiv_pkg::*; #(
  parameter int CNT_W       = 26,
  parameter int DEFAULT_DIV = DEFAULT_DIV_C
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_val,
  output logic             clk_div,
  output logic             tick
);

  chan_state_t st_q, st_d;
  logic        tick_q, tick_d;
  logic        term;

  always_comb begin
    st_d   = st_q;
    tick_d = 1'b0;
    term   = (st_q.cnt == st_q.div_act - 1'b1);

    if (st_q.div_act == '0) begin
      st_d.cnt     = '0;
      st_d.clk_div = 1'b0;
      if (st_q.pending) begin
        st_d.div_act = st_q.div_shadow;
        st_d.pending = 1'b0;
      end
    end else if (!en) begin
      // Paused channel takes a pending divisor straight away without toggling.
      if (st_q.pending) begin
        st_d.div_act = st_q.div_shadow;
        st_d.cnt     = '0;
        st_d.pending = 1'b0;
      end
    end else if (term) begin
      st_d.cnt     = '0;
      st_d.clk_div = ~st_q.clk_div;
      tick_d       = ~st_q.clk_div;
      if (st_q.pending) begin
        st_d.div_act = st_q.div_shadow;
        st_d.pending = 1'b0;
      end
    end else begin
      st_d.cnt = st_q.cnt + 1'b1;
    end

    // A write on the commit edge lands after the commit, so it stays pending.
    if (wr) begin
      st_d.div_shadow = MAX_CNT_W'(wr_val);
      st_d.pending    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= '{cnt:        '0,
                div_act:    MAX_CNT_W'(DEFAULT_DIV),
                div_shadow: MAX_CNT_W'(DEFAULT_DIV),
                pending:    1'b0,
                clk_div:    1'b0};
      tick_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      tick_q <= tick_d;
    end
  end

  assign clk_div = st_q.clk_div;
  assign tick    = tick_q;

endmodule

// File: rtl/clkdiv_multi.sv
// rtl/clkdiv_multi.sv - multi-channel programmable clock divider with divisor load handshake
module clkdiv_multi import clkdiv_pkg::*; #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 26,
  parameter int DEFAULT_DIV = DEFAULT_DIV_C
) (
  input  logic           clk,
  input  logic           rst,
  clkdiv_multi_if.slave  bus
);

  logic              load_valid;
  logic              load_ack_q, load_ack_d;
  logic              load_err_q, load_err_d;
  logic [NUM_CH-1:0] wr;
  logic [NUM_CH-1:0] clk_div_w;
  logic [NUM_CH-1:0] tick_w;

  always_comb begin
    load_valid = bus.load && (32'(bus.load_ch) < 32'(NUM_CH));
    load_ack_d = load_valid;
    load_err_d = bus.load && !load_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_ack_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      load_ack_q <= load_ack_d;
      load_err_q <= load_err_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr[i] = load_valid && (32'(bus.load_ch) == 32'(i));

    clkdiv_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .en      (bus.en[i]),
      .wr      (wr[i]),
      .wr_val  (bus.load_val),
      .clk_div (clk_div_w[i]),
      .tick    (tick_w[i])
    );
  end

  assign bus.clk_div  = clk_div_w;
  assign bus.tick     = tick_w;
  assign bus.load_ack = load_ack_q;
  assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_clkdiv_multi.sv
// tb/tb_clkdiv_multi.sv - scoreboard bench for clkdiv_multi against a cycle reference model
module tb_clkdiv_multi;

  logic clk;
  logic rst;

  clkdiv_multi_if #(.NUM_CH(2), .CNT_W(8)) bus  ();
  clkdiv_multi_if #(.NUM_CH(3), .CNT_W(8)) bus3 ();

  clkdiv_multi #(.NUM_CH(2), .CNT_W(8), .DEFAULT_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Three-channel instance so that an out-of-range load_ch is representable.
  clkdiv_multi #(.NUM_CH(3), .CNT_W(8), .DEFAULT_DIV(4)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [5:0] exp_q  [$];
  logic [4:0] exp3_q [$];

  // Reference model: each channel is a level, a position within its half period,
  // the half period in force, and an optional queued replacement half period.
  int pos    [2];
  int half   [2];
  int queued [2];
  bit has_q  [2];
  bit level  [2];
  bit rise   [2];

  task automatic step(input bit r, input bit [1:0] e, input bit ld, input bit ch,
                      input int val, input bit ld3, input bit [1:0] ch3);
    bit ack, err, ack3, err3;
    @(negedge clk);
    rst           = r;
    bus.en        = e;
    bus.load      = ld;
    bus.load_ch   = ch;
    bus.load_val  = 8'(val);
    bus3.en       = 3'b000;
    bus3.load     = ld3;
    bus3.load_ch  = ch3;
    bus3.load_val = 8'd7;

    for (int i = 0; i < 2; i++) begin
      rise[i] = 1'b0;
      if (r) begin
        pos[i] = 0; half[i] = 4; queued[i] = 4; has_q[i] = 0; level[i] = 0;
        continue;
      end
      if (half[i] == 0) begin
        pos[i] = 0; level[i] = 0;
        if (has_q[i]) begin half[i] = queued[i]; has_q[i] = 0; end
      end else if (!e[i]) begin
        if (has_q[i]) begin half[i] = queued[i]; has_q[i] = 0; pos[i] = 0; end
      end else if (pos[i] + 1 == half[i]) begin
        pos[i]   = 0;
        level[i] = !level[i];
        rise[i]  = level[i];
        if (has_q[i]) begin half[i] = queued[i]; has_q[i] = 0; end
      end else begin
        pos[i]++;
      end
      if (ld && int'(ch) == i) begin queued[i] = val; has_q[i] = 1; end
    end
    ack  = !r && ld;
    err  = 1'b0;
    ack3 = !r && ld3 && (ch3 < 3);
    err3 = !r && ld3 && (ch3 >= 3);
    exp_q.push_back({level[1], level[0], rise[1], rise[0], ack, err});
    exp3_q.push_back({3'b000, ack3, err3});
  endtask

  task automatic run(input int n, input bit [1:0] e);
    for (int k = 0; k < n; k++) step(0, e, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    logic [5:0] exp, got;
    logic [4:0] exp3, got3;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        got = {bus.clk_div, bus.tick, bus.load_ack, bus.load_err};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL main cyc %0d {clk_div,tick,ack,err} got %b exp %b", cyc, got, exp);
        end
      end
      if (exp3_q.size() > 0) begin
        exp3 = exp3_q.pop_front();
        got3 = {bus3.clk_div, bus3.load_ack, bus3.load_err};
        checks++;
        if (got3 !== exp3) begin
          errors++;
          $display("FAIL dut3 cyc %0d {clk_div,ack,err} got %b exp %b", cyc, got3, exp3);
        end
      end
    end
  end

  initial begin : stimulus
    rst = 1'b1;
    bus.en = '0; bus.load = 0; bus.load_ch = 0; bus.load_val = '0;
    bus3.en = '0; bus3.load = 0; bus3.load_ch = 0; bus3.load_val = '0;

    // Reset then free-running on both channels.
    for (int k = 0; k < 3; k++) step(1, 2'b11, 0, 0, 0, 0, 0);
    run(40, 2'b11);

    // Reset pulse mid-operation.
    run(5, 2'b11);
    step(1, 2'b11, 0, 0, 0, 0, 0);
    run(12, 2'b11);

    // Divisor load mid-period on channel 0.
    step(0, 2'b11, 1, 0, 2, 0, 0);
    run(20, 2'b11);

    // Pause channel 1 for 5 cycles.
    run(1, 2'b11);
    run(5, 2'b01);
    run(12, 2'b11);

    // Stall channel 0 with a zero divisor, then restart it.
    step(0, 2'b11, 1, 0, 0, 0, 0);
    run(12, 2'b11);
    step(0, 2'b11, 1, 0, 3, 0, 0);
    run(15, 2'b11);

    // Invalid and valid loads on the three-channel instance.
    step(0, 2'b11, 0, 0, 0, 1, 2'd3);
    step(0, 2'b11, 0, 0, 0, 0, 2'd0);
    step(0, 2'b11, 0, 0, 0, 1, 2'd2);
    step(0, 2'b11, 0, 0, 0, 1, 2'd3);

    // Back-to-back loads before the terminal count: last value wins.
    step(0, 2'b11, 1, 0, 5, 0, 0);
    step(0, 2'b11, 1, 0, 6, 0, 0);
    run(30, 2'b11);

    // Randomised traffic.
    for (int k = 0; k < 3000; k++) begin
      bit        r, ld, ld3;
      bit [1:0]  e, ch3;
      bit        ch;
      int        val;
      r   = ($urandom_range(0, 299) == 0);
      e   = {($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0)};
      ld  = ($urandom_range(0, 9) == 0);
      ch  = 1'($urandom_range(0, 1));
      val = $urandom_range(0, 7);
      ld3 = ($urandom_range(0, 3) == 0);
      ch3 = 2'($urandom_range(0, 3));
      step(r, e, ld, ch, val, ld3, ch3);
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || exp3_q.size() != 0) begin
      errors++;
      $display("FAIL drain leftover got %0d/%0d exp 0/0", exp_q.size(), exp3_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
